black_box_xform: RTL and testbench

BLACK_BOX_XFORM -- requirements
Module: black_box_xform

---
 rtl/black_box_xform.sv | 110 +++++++++++
 tb/tb_black_box_xform.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/black_box_xform.sv
// Valid/ready pipeline that applies a mode-selected transform (pass, xor, increment,
// running accumulate) to each accepted beat and delivers it DEPTH cycles later in order.
module black_box_xform #(
  parameter int               WIDTH   = 4,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] XOR_KEY = WIDTH'('hC),
  parameter logic [WIDTH-1:0] ADD_INC = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] from,
  input  logic             from_valid,
  output logic             from_ready,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] to,
  output logic             to_carry,
  output logic             to_valid,
  input  logic             to_ready,
  output logic [15:0]      beat_count
);

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_XOR  = 2'd1,
    MODE_INC  = 2'd2,
    MODE_ACC  = 2'd3
  } mode_e;

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] carry_q;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] ready;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] x_data;
  logic             x_carry;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH:0]   acc_sum;
  logic             in_fire;
  logic             out_fire;

  assign inc_sum = {1'b0, from} + {1'b0, ADD_INC};
  assign acc_sum = {1'b0, acc_q} + {1'b0, from};

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    x_data  = from;
    x_carry = 1'b0;
    case (mode_e'(mode))
      MODE_PASS: x_data = from;
      MODE_XOR:  x_data = from ^ XOR_KEY;
      MODE_INC: begin
        x_data  = inc_sum[WIDTH-1:0];
        x_carry = inc_sum[WIDTH];
      end
      MODE_ACC: begin
        x_data  = acc_sum[WIDTH-1:0];
        x_carry = acc_sum[WIDTH];
      end
      default: x_data = from;
    endcase
  end

  // A stage may load when it is empty or its contents move on this same edge.
  always_comb begin : ready_chain
    logic r;
    ready          = '0;
    r              = !valid_q[DEPTH-1] || to_ready;
    ready[DEPTH-1] = r;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      r        = !valid_q[k] || r;
      ready[k] = r;
    end
  end

  assign from_ready = !rst && ready[0];
  assign in_fire    = from_valid && from_ready;
  assign out_fire   = to_valid && to_ready;

  assign to       = data_q[DEPTH-1];
  assign to_carry = carry_q[DEPTH-1];
  assign to_valid = valid_q[DEPTH-1];

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: stage data is cleared too, so the output bus reads zero straight out of reset.
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
      carry_q    <= '0;
      valid_q    <= '0;
      acc_q      <= '0;
      beat_count <= '0;
    end else begin
      if (ready[0]) begin
        valid_q[0] <= in_fire;
        data_q[0]  <= x_data;
        carry_q[0] <= x_carry;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (ready[k]) begin
          valid_q[k] <= valid_q[k-1];
          data_q[k]  <= data_q[k-1];
          carry_q[k] <= carry_q[k-1];
        end
      end
      if (in_fire && mode_e'(mode) == MODE_ACC) acc_q <= acc_sum[WIDTH-1:0];
      if (out_fire) beat_count <= beat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_black_box_xform.sv
// Directed bench for black_box_xform at WIDTH=4, DEPTH=2 with hand-computed expectations.
module tb_black_box_xform;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  from;
  logic        from_valid;
  logic        from_ready;
  logic [1:0]  mode;
  logic [3:0]  to;
  logic        to_carry;
  logic        to_valid;
  logic        to_ready;
  logic [15:0] beat_count;

  int vectors     = 0;
  int miscompares = 0;

  black_box_xform #(.WIDTH(4), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .from       (from),
    .from_valid (from_valid),
    .from_ready (from_ready),
    .mode       (mode),
    .to         (to),
    .to_carry   (to_carry),
    .to_valid   (to_valid),
    .to_ready   (to_ready),
    .beat_count (beat_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst        = 1'b1;
    from       = 4'h0;
    from_valid = 1'b0;
    mode       = 2'd0;
    to_ready   = 1'b1;
    tick();
    tick();
    check("rst_to_valid", to_valid, 0);
    check("rst_to", to, 0);
    check("rst_to_carry", to_carry, 0);
    check("rst_beat_count", beat_count, 0);
    check("rst_from_ready", from_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_from_ready", from_ready, 1);

    // Mode 1: 3 ^ C = F, visible after the second edge.
    from = 4'h3; mode = 2'd1; from_valid = 1'b1;
    tick();
    from_valid = 1'b0;
    check("xor_latency_not_early", to_valid, 0);
    tick();
    check("xor_valid", to_valid, 1);
    check("xor_data", to, 4'hF);
    check("xor_carry", to_carry, 0);
    tick();
    check("xor_count", beat_count, 1);
    check("xor_drained", to_valid, 0);

    // Mode 2: F + 1 wraps to 0 with carry.
    from = 4'hF; mode = 2'd2; from_valid = 1'b1;
    tick();
    from_valid = 1'b0;
    tick();
    check("inc_data", to, 4'h0);
    check("inc_carry", to_carry, 1);
    tick();
    check("inc_count", beat_count, 2);

    // Mode 3 back-to-back: acc 0->5->C->2, outputs 5, C, 2(carry).
    mode = 2'd3; from = 4'h5; from_valid = 1'b1;
    tick();
    from = 4'h7;
    tick();
    check("acc0_data", to, 4'h5);
    check("acc0_carry", to_carry, 0);
    from = 4'h6;
    tick();
    check("acc1_data", to, 4'hC);
    check("acc1_carry", to_carry, 0);
    from_valid = 1'b0;
    tick();
    check("acc2_data", to, 4'h2);
    check("acc2_carry", to_carry, 1);
    tick();
    check("acc_count", beat_count, 5);
    // Adding zero in mode 3 exposes the accumulator without changing it.
    from = 4'h0; from_valid = 1'b1;
    tick();
    from_valid = 1'b0;
    tick();
    check("acc_value", to, 4'h2);
    check("acc_value_carry", to_carry, 0);
    tick();
    check("acc_probe_count", beat_count, 6);

    // Backpressure: only 1 and 2 fit, 3 waits.
    to_ready = 1'b0; mode = 2'd0; from = 4'h1; from_valid = 1'b1;
    tick();
    from = 4'h2;
    check("bp_ready_second", from_ready, 1);
    tick();
    from = 4'h3;
    check("bp_full_ready", from_ready, 0);
    check("bp_head", to, 4'h1);
    check("bp_head_valid", to_valid, 1);
    tick();
    check("bp_hold_data", to, 4'h1);
    check("bp_hold_ready", from_ready, 0);
    check("bp_hold_count", beat_count, 6);
    to_ready = 1'b1;
    #1;
    check("bp_release_ready", from_ready, 1);
    tick();
    from_valid = 1'b0;
    check("bp_out2", to, 4'h2);
    tick();
    check("bp_out3", to, 4'h3);
    tick();
    check("bp_drained", to_valid, 0);
    // Three more transfers on top of the six before.
    check("bp_count", beat_count, 9);

    // Mid-stream reset: two mode-3 beats in flight (acc 2->6->B) are discarded.
    to_ready = 1'b0; mode = 2'd3; from = 4'h4; from_valid = 1'b1;
    tick();
    from = 4'h5;
    tick();
    check("mid_full", from_ready, 0);
    rst = 1'b1; from = 4'h7; from_valid = 1'b1;
    tick();
    check("mid_rst_valid", to_valid, 0);
    check("mid_rst_count", beat_count, 0);
    check("mid_rst_ready", from_ready, 0);
    rst = 1'b0; from_valid = 1'b0; to_ready = 1'b1;
    #1;
    check("mid_release_ready", from_ready, 1);
    tick();
    check("mid_no_ghost", to_valid, 0);
    tick();
    check("mid_no_ghost2", to_valid, 0);
    from = 4'h0; from_valid = 1'b1;
    tick();
    from_valid = 1'b0;
    tick();
    check("mid_acc_cleared", to, 4'h0);
    check("mid_acc_valid", to_valid, 1);
    tick();
    check("mid_count", beat_count, 1);

    // Stream until the counter wraps.
    mode = 2'd0; from = 4'hA; from_valid = 1'b1;
    for (int i = 0; i < 70000 && beat_count != 16'hFFFD; i++) tick();
    from_valid = 1'b0;
    check("stream_reach", beat_count, 16'hFFFD);
    tick();
    tick();
    check("stream_max", beat_count, 16'hFFFF);
    check("stream_last_data", to, 4'hA);
    tick();
    check("stream_idle", to_valid, 0);
    from = 4'h9; from_valid = 1'b1;
    tick();
    from_valid = 1'b0;
    tick();
    check("wrap_data", to, 4'h9);
    tick();
    check("wrap_count", beat_count, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
